// File: rtl/sequential_multiplier_if.sv
// Handshake and data bundle between the ALU control (master) and the
// sequential multiplier (slave).
//
// Handshake: the master raises start with a/b valid. The slave accepts it
// only on an edge where it is not computing, i.e. while busy is low. Once
// accepted, a/b are captured and may change freely. done pulses for
// exactly one cycle and product is valid with it. product then holds until
// the next completion. There is no backpressure: the master must watch
// busy/done and must not assume that a start raised mid-operation will be
// remembered.
interface sequential_multiplier_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] product;
  logic        busy;
  logic        done;
  // Debug view of the FSM state: 0 = IDLE, 1 = RUN, 2 = DONE.
  logic [1:0]  state;

  modport master (
    output start, a, b,
    input  product, busy, done, state
  );

  modport slave (
    input  start, a, b,
    output product, busy, done, state
  );
endinterface

// File: rtl/sequential_multiplier.sv
// Iterative 32x32 unsigned shift-and-add multiplier.
//
// One multiplier bit is consumed per cycle. The partial product is the
// multiplicand ANDed with the current LSB of the multiplier. That value is
// added into the upper half of a 65-bit accumulator {c, hi, lo}. The whole
// accumulator then shifts right by one, so the multiplier bits drain out of
// lo while the product bits fill in from the top. After 32 iterations,
// {hi, lo} holds the exact 64-bit product.
module sequential_multiplier (
  input  logic clk,
  input  logic rst_n,
  sequential_multiplier_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q,   state_d;
  logic [31:0] mcand_q,   mcand_d;
  logic        c_q,       c_d;
  logic [31:0] hi_q,      hi_d;
  logic [31:0] lo_q,      lo_d;
  logic [4:0]  count_q,   count_d;
  logic [63:0] product_q, product_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;

  logic [31:0] addend;
  logic [32:0] sum;
  logic [64:0] acc_next;
  logic        load;

  // Datapath for one iteration: AND-gated addend, 33-bit sum, then shift.
  always_comb begin
    addend   = mcand_q & {32{lo_q[0]}};
    sum      = {c_q, hi_q} + {1'b0, addend};
    acc_next = {sum, lo_q} >> 1;
  end

  // An operation is accepted in IDLE. It is also accepted on the edge that
  // leaves DONE, because the machine returns to IDLE on that same edge. This
  // gives back-to-back operations a 33-cycle spacing. A start seen earlier,
  // during RUN or inside DONE, is not remembered.
  always_comb begin
    load = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  // Next-state and register-update logic for the FSM and datapath.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    c_d       = c_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_RUN: begin
        c_d     = acc_next[64];
        hi_d    = acc_next[63:32];
        lo_d    = acc_next[31:0];
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          product_d = acc_next[63:0];
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (load) begin
      mcand_d = bus.a;
      c_d     = 1'b0;
      hi_d    = 32'd0;
      lo_d    = bus.b;
      count_d = 5'd0;
      state_d = S_RUN;
      busy_d  = 1'b1;
    end
  end

  // State registers; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= 32'd0;
      c_q       <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      count_q   <= 5'd0;
      product_q <= 64'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      c_q       <= c_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    bus.product = product_q;
    bus.busy    = busy_q;
    bus.done    = done_q;
    bus.state   = state_q;
  end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench for sequential_multiplier: table-driven products plus
// hand-written reset, hold, back-to-back and abort sequences.
module tb_sequential_multiplier;

  logic clk;
  logic rst_n;
  sequential_multiplier_if m_if ();

  sequential_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if.slave)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Driver + scoreboard for one operation. Starts at a negedge with the
  // machine idle. It checks busy length, done latency (32 edges after the
  // start edge), the result, that product held beforehand, and that done
  // is a single pulse.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [63:0] exp, input string name);
    int lat;
    int busy_cnt;
    int held_bad;
    logic [63:0] pre_prod;
    logic [63:0] got;
    lat      = -1;
    busy_cnt = 0;
    held_bad = 0;
    got      = '0;
    @(negedge clk);
    pre_prod   = m_if.product;
    m_if.start = 1'b1;
    m_if.a     = op_a;
    m_if.b     = op_b;
    exp_q.push_back(exp);
    @(posedge clk);                 // E0
    @(negedge clk);
    m_if.start = 1'b0;
    m_if.a     = ~op_a;             // changes after the start edge must not matter
    m_if.b     = op_b ^ 32'h5A5A5A5A;
    if (m_if.busy) busy_cnt++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_if.done) begin
        lat = k;
        got = m_if.product;
        break;
      end
      if (m_if.busy) busy_cnt++;
      if (m_if.product !== pre_prod) held_bad++;
    end
    check({name, " latency"}, 64'(lat), 64'd32);
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({name, " product_held"}, 64'(held_bad), 64'd0);
    check({name, " busy_in_done"}, 64'(m_if.busy), 64'd0);
    check({name, " product"}, got, exp_q.pop_front());
    @(negedge clk);
    check({name, " done_pulse"}, 64'(m_if.done), 64'd0);
    check({name, " idle_state"}, 64'(m_if.state), 64'd0);
  endtask

  initial begin
    int done_at[$];
    int bad;
    m_if.start = 1'b0;
    m_if.a     = '0;
    m_if.b     = '0;
    rst_n      = 1'b0;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1] = '{32'h00000000, 32'hDEADBEEF, 64'h0000000000000000};
    vecs[2] = '{32'h12345678, 32'h00000001, 64'h0000000012345678};
    vecs[3] = '{32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001};
    vecs[4] = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[5] = '{32'h00010000, 32'h00010000, 64'h0000000100000000};
    vecs[6] = '{32'hAAAAAAAA, 32'h00000003, 64'h00000001FFFFFFFE};
    vecs[7] = '{32'h00000001, 32'hFFFFFFFF, 64'h00000000FFFFFFFF};

    // Reset state before any clock edge.
    #2;
    check("reset product", m_if.product, 64'd0);
    check("reset busy", 64'(m_if.busy), 64'd0);
    check("reset done", 64'(m_if.done), 64'd0);
    check("reset state", 64'(m_if.state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic product and hold afterwards.
    run_op(32'd3, 32'd5, 64'd15, "basic");
    repeat (10) @(negedge clk);
    check("basic hold", m_if.product, 64'd15);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Start held high through RUN and DONE: second op starts at E33.
    @(negedge clk);
    m_if.start = 1'b1;
    m_if.a     = 32'd7;
    m_if.b     = 32'd6;
    @(posedge clk);                 // E0
    @(negedge clk);
    m_if.a = 32'h0000FFFF;
    m_if.b = 32'h0000FFFF;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 33) m_if.start = 1'b0;
      if (m_if.done) begin
        done_at.push_back(k);
        if (k == 32) check("b2b first product", m_if.product, 64'd42);
        if (k == 65) check("b2b second product", m_if.product, 64'h00000000FFFE0001);
      end
      if (k == 50) check("b2b hold", m_if.product, 64'd42);
    end
    check("b2b done count", 64'(done_at.size()), 64'd2);
    if (done_at.size() == 2) begin
      check("b2b first done edge", 64'(done_at[0]), 64'd32);
      check("b2b second done edge", 64'(done_at[1]), 64'd65);
    end

    // Reset during iteration 15 aborts the operation.
    @(negedge clk);
    m_if.start = 1'b1;
    m_if.a     = 32'd100;
    m_if.b     = 32'd100;
    @(posedge clk);                 // E0
    @(negedge clk);
    m_if.start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_if.done) bad++;
    end
    check("abort busy mid-run", 64'(m_if.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort product", m_if.product, 64'd0);
    check("abort busy", 64'(m_if.busy), 64'd0);
    check("abort state", 64'(m_if.state), 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (m_if.done) bad++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (m_if.done) bad++;
    end
    check("abort no done", 64'(bad), 64'd0);
    check("abort product stays 0", m_if.product, 64'd0);
    run_op(32'd2, 32'd9, 64'd18, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
